shift_left_seq: RTL

Iterative 16-bit logical shift-left unit for the ALU16b datapath. It is the left-direction counterpart of the combinational arithmetic shift-right. It shifts operand A left by the amount in B, one bit per clock, under a start/done handshake. Out-of-range amounts are resolved in a single cycle. It replaces a wide left barrel shifter on multi-cycle shift instructions and also supplies carry-out and zero flags to the flag logic.

---
 rtl/shift_left_seq.sv | 85 ++++++++
 1 files changed

// File: rtl/shift_left_seq.sv
// shift_left_seq: iterative 16-bit logical shift-left, one bit per clock.
// Ports: CLK, RST, Start, A, B in; O, Busy, Done, Carry, Zero out.
module shift_left_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] O,
  output logic        Busy,
  output logic        Done,
  output logic        Carry,
  output logic        Zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] r_q, r_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        c_q, c_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (Start) begin
          state_d = DONE;
          if (B == 16'd0) begin
            r_d = A;
            c_d = 1'b0;
          end else if (B <= 16'd15) begin
            r_d     = A;
            c_d     = 1'b0;
            cnt_d   = B[4:0];
            state_d = SHIFT;
          end else if (B == 16'd16) begin
            // Sixteen shifts leave bit 0 as the last bit out.
            r_d = '0;
            c_d = A[0];
          end else begin
            r_d = '0;
            c_d = 1'b0;
          end
        end
      end
      SHIFT: begin
        r_d   = {r_q[14:0], 1'b0};
        c_d   = r_q[15];
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign O     = r_q;
  assign Carry = c_q;
  assign Zero  = (r_q == 16'd0);
  assign Busy  = (state_q == SHIFT);
  assign Done  = (state_q == DONE);

endmodule
